muldiv_unit: RTL

Iterative RV32M multiply/divide unit for the pipelined RV32I core, parametrised in operand width. It sits beside the single-cycle ALU in the execute stage and takes over M-extension instructions. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU one bit per cycle, with valid/ready handshakes on both sides so the pipeline can stall on it. A flush input lets the pipeline abort an in-flight operation.

---
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one product or quotient bit per cycle.
// Valid/ready on both sides; flush aborts an in-flight operation.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic            a_sg, b_sg, a_neg, b_neg;
  logic            is_div, is_rem, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  logic [XLEN-1:0]   hi, lo, shi, slo, qr, fin;
  logic [XLEN:0]     msum, dsh, ddiff;
  logic [2*XLEN-1:0] step, prod;

  always_comb begin
    a_sg = 1'b0;
    b_sg = 1'b0;
    case (op)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_sg = 1'b1;
        b_sg = 1'b1;
      end
      3'b010:  a_sg = 1'b1;
      default: ;
    endcase
  end

  assign a_neg  = a_sg & A[XLEN-1];
  assign b_neg  = b_sg & B[XLEN-1];
  assign a_mag  = a_neg ? -A : A;
  assign b_mag  = b_neg ? -B : B;
  assign is_div = op[2];
  assign is_rem = op[2] & op[1];
  assign div0   = is_div & (B == '0);
  assign ovf    = is_div & ~op[0] & (A == MIN) & (B == '1);

  always_comb begin
    spec_res = '0;
    if (div0)     spec_res = is_rem ? A : '1;
    else if (ovf) spec_res = is_rem ? '0 : A;
  end

  assign hi = acc_q[2*XLEN-1:XLEN];
  assign lo = acc_q[XLEN-1:0];

  // Multiply: add multiplicand into the high half, shift the pair right.
  assign msum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
  // Divide: shift remainder:dividend left, keep the difference if no borrow.
  assign dsh   = {hi, lo[XLEN-1]};
  assign ddiff = dsh - {1'b0, opnd_q};

  always_comb begin
    if (op_q[2])
      step = {ddiff[XLEN] ? dsh[XLEN-1:0] : ddiff[XLEN-1:0],
              lo[XLEN-2:0], ~ddiff[XLEN]};
    else
      step = {msum, lo[XLEN-1:1]};
  end

  assign shi  = step[2*XLEN-1:XLEN];
  assign slo  = step[XLEN-1:0];
  assign prod = neg_q ? -step : step;
  assign qr   = op_q[1] ? shi : slo;

  always_comb begin
    if (op_q[2])
      fin = neg_q ? -qr : qr;
    else if (op_q[1:0] == 2'b00)
      fin = prod[XLEN-1:0];
    else
      fin = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    spec_d  = spec_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    res_d   = res_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          op_d    = op;
          neg_d   = is_rem ? a_neg : (a_neg ^ b_neg);
          spec_d  = div0 | ovf;
          state_d = CALC;
          if (div0 | ovf) begin
            cnt_d = CW'(1);
            res_d = spec_res;
          end else begin
            cnt_d  = CW'(XLEN);
            acc_d  = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
            opnd_d = is_div ? b_mag : a_mag;
          end
        end
        CALC: begin
          cnt_d = cnt_q - CW'(1);
          if (!spec_q) acc_d = step;
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            if (!spec_q) res_d = fin;
          end
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      spec_q  <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      spec_q  <= spec_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Result    = res_q;

endmodule
